// File: rtl/memory_responder.sv
// Byte-addressed memory answering the control unit's MemEn/MOC handshake.
// Four byte-lane banks give a big-endian word per access after WAIT_CYCLES wait states.
module memory_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemEn,
    input  logic              RW,
    input  logic [1:0]        DataType,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              MOC,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              busy
);

    localparam int          ROW_W     = ADDR_W - 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [1:0]  SZ_BYTE   = 2'd0;
    localparam logic [1:0]  SZ_HALF   = 2'd1;
    localparam logic [1:0]  SZ_WORD   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic               rw_reg;
    logic [1:0]         size_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [31:0]        wdata_reg;
    logic [31:0]        data_out_reg;

    logic               accept;
    logic               commit;
    logic               load;
    logic [1:0]         size_in;
    logic [ADDR_W-1:0]  addr_aligned;
    logic [ROW_W-1:0]   rd_row;
    logic [ROW_W-1:0]   wr_row;
    logic [7:0]         q_bytes [4];
    logic [31:0]        rd_word;

    // Reserved DataType 11 behaves as a word access.
    always_comb begin
        size_in = SZ_WORD;
        case (DataType)
            2'b00:   size_in = SZ_BYTE;
            2'b01:   size_in = SZ_HALF;
            default: size_in = SZ_WORD;
        endcase
    end

    always_comb begin
        addr_aligned = addr;
        case (size_in)
            SZ_BYTE: addr_aligned = addr;
            SZ_HALF: addr_aligned = {addr[ADDR_W-1:1], 1'b0};
            default: addr_aligned = {addr[ADDR_W-1:2], 2'b00};
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        commit     = 1'b0;
        load       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (MemEn) begin
                    accept     = 1'b1;
                    cnt_next   = WAIT_INIT;
                    state_next = S_ACCESS;
                end else if (ld_en) begin
                    load = 1'b1;
                end
            end
            S_ACCESS: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    commit     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!MemEn) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_reg    <= 1'b0;
            size_reg  <= SZ_BYTE;
            addr_reg  <= '0;
            wdata_reg <= 32'h0;
        end else if (accept) begin
            rw_reg    <= RW;
            size_reg  <= size_in;
            addr_reg  <= addr_aligned;
            wdata_reg <= data_in;
        end
    end

    // Banks are read every cycle: at acceptance from the incoming address, afterwards
    // from the latched one, so the completing edge always finds the row already fetched.
    assign rd_row = (state_reg == S_IDLE) ? addr[ADDR_W-1:2] : addr_reg[ADDR_W-1:2];
    assign wr_row = load ? ld_addr[ADDR_W-1:2] : addr_reg[ADDR_W-1:2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            localparam logic [1:0] LANE = 2'(gi);

            logic [7:0] mem [0:(1<<ROW_W)-1];
            logic [7:0] q_reg;
            logic       lane_sel;
            logic       we;
            logic [7:0] wbyte;

            always_comb begin
                lane_sel = 1'b0;
                we       = 1'b0;
                wbyte    = ld_data;
                case (size_reg)
                    SZ_BYTE: lane_sel = (addr_reg[1:0] == LANE);
                    SZ_HALF: lane_sel = (addr_reg[1] == LANE[1]);
                    default: lane_sel = 1'b1;
                endcase
                if (load) begin
                    we    = (ld_addr[1:0] == LANE);
                    wbyte = ld_data;
                end else begin
                    we = commit && !rw_reg && lane_sel;
                    case (size_reg)
                        SZ_BYTE: wbyte = wdata_reg[7:0];
                        SZ_HALF: wbyte = LANE[0] ? wdata_reg[7:0] : wdata_reg[15:8];
                        default: wbyte = wdata_reg[31-8*gi -: 8];
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (we) begin
                    mem[wr_row] <= wbyte;
                end
                q_reg <= mem[rd_row];
            end

            assign q_bytes[gi] = q_reg;
        end
    endgenerate

    // Big-endian: lane 0 (lowest address) is the most significant byte of the access.
    always_comb begin
        rd_word = 32'h0;
        case (size_reg)
            SZ_BYTE: rd_word = {24'h0, q_bytes[addr_reg[1:0]]};
            SZ_HALF: rd_word = addr_reg[1] ? {16'h0, q_bytes[2], q_bytes[3]}
                                           : {16'h0, q_bytes[0], q_bytes[1]};
            default: rd_word = {q_bytes[0], q_bytes[1], q_bytes[2], q_bytes[3]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_reg <= 32'h0;
        end else if (commit && rw_reg) begin
            data_out_reg <= rd_word;
        end
    end

    assign data_out = data_out_reg;
    assign MOC      = (state_reg == S_DONE);
    assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (2 and 0 wait states) against a
// byte-array transaction model, plus directed literal checks.
module tb_memory_responder;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       memen;
    logic             rw;
    logic [1:0]       dt;
    logic [7:0]       addr;
    logic [31:0]      din;
    logic             ld_en;
    logic [7:0]       ld_addr;
    logic [7:0]       ld_data;
    logic [1:0][31:0] dout;
    logic [1:0]       moc;
    logic [1:0]       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .MemEn(memen[0]), .RW(rw), .DataType(dt),
        .addr(addr), .data_in(din), .data_out(dout[0]), .MOC(moc[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy[0])
    );

    memory_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .MemEn(memen[1]), .RW(rw), .DataType(dt),
        .addr(addr), .data_in(din), .data_out(dout[1]), .MOC(moc[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy[1])
    );

    function automatic int wait_of(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a plain byte array plus "cycles since acceptance".
    logic [7:0]  m [2][256];
    int          phase [2];     // 0 idle, 1 waiting, 2 complete
    int          age [2];
    logic        t_rw [2];
    int          t_n [2];
    int          t_a [2];
    logic [31:0] t_wd [2];
    logic [31:0] exp_dout [2];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                phase[d]    = 0;
                age[d]      = 0;
                exp_dout[d] = 32'h0;
            end else begin
                case (phase[d])
                    0: begin
                        if (memen[d]) begin
                            t_rw[d] = rw;
                            t_n[d]  = (dt == 2'b00) ? 1 : (dt == 2'b01) ? 2 : 4;
                            t_a[d]  = int'(addr) - (int'(addr) % t_n[d]);
                            t_wd[d] = din;
                            age[d]  = 0;
                            phase[d] = 1;
                        end else if (ld_en) begin
                            m[d][ld_addr] = ld_data;
                        end
                    end
                    1: begin
                        age[d]++;
                        if (age[d] == wait_of(d) + 1) begin
                            if (t_rw[d]) begin
                                logic [31:0] v;
                                v = 32'h0;
                                for (int i = 0; i < t_n[d]; i++)
                                    v = (v << 8) | 32'(m[d][(t_a[d] + i) % 256]);
                                exp_dout[d] = v;
                            end else begin
                                for (int i = 0; i < t_n[d]; i++)
                                    m[d][(t_a[d] + i) % 256] = 8'(t_wd[d] >> (8 * (t_n[d] - 1 - i)));
                            end
                            phase[d] = 2;
                        end
                    end
                    default: begin
                        if (!memen[d]) phase[d] = 0;
                    end
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("moc%0d", d), 32'(moc[d]), 32'(phase[d] == 2));
            chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(phase[d] != 0));
            chk($sformatf("data_out%0d", d), dout[d], exp_dout[d]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_byte(logic [7:0] a, logic [7:0] v);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = v;
        tick();
        ld_en = 1'b0;
    endtask

    // Runs one request on instance d; lat = edges from acceptance to MOC seen high.
    task automatic txn(int d, logic r, logic [1:0] t, logic [7:0] a, logic [31:0] wd,
                       int hold, bit early, output logic [31:0] rdv, output int lat);
        int n;
        rw       = r;
        dt       = t;
        addr     = a;
        din      = wd;
        memen[d] = 1'b1;
        tick();
        ld_en = 1'b0;
        lat   = 0;
        if (early) begin
            tick();
            memen[d] = 1'b0;
            lat = 1;
        end
        n = 0;
        while (!moc[d] && n < 40) begin
            tick();
            n++;
        end
        lat = lat + n;
        if (!moc[d]) chk($sformatf("moc_timeout%0d", d), 32'(moc[d]), 32'd1);
        rdv = dout[d];
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                chk($sformatf("moc_hold%0d", d), 32'(moc[d]), 32'd1);
            end
        end
        memen[d] = 1'b0;
        n = 0;
        while (busy[d] && n < 10) begin
            tick();
            n++;
        end
        if (busy[d]) chk($sformatf("busy_timeout%0d", d), 32'(busy[d]), 32'd0);
        $display("txn dut%0d %s dt=%0d addr=%h wdata=%h rdata=%h lat=%0d",
                 d, r ? "RD" : "WR", t, a, wd, rdv, lat);
    endtask

    initial begin
        logic [31:0] rv;
        int          lat;

        rst_n = 1'b0;
        memen = 2'b00;
        rw = 1'b1; dt = 2'b10; addr = 8'h0; din = 32'h0;
        ld_en = 1'b0; ld_addr = 8'h0; ld_data = 8'h0;
        tick(); tick();
        chk("reset_moc", 32'(moc), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_data_out", dout[0], 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 256; i++)
            load_byte(8'(i), (i >= 8'h20 && i < 8'h24) ? 8'h00 : 8'($urandom));
        load_byte(8'h10, 8'hE3); load_byte(8'h11, 8'hA0);
        load_byte(8'h12, 8'h00); load_byte(8'h13, 8'h05);

        // Preload and word read, 2 wait states
        txn(0, 1'b1, 2'b10, 8'h10, 32'h0, 0, 1'b0, rv, lat);
        chk("word_read", rv, 32'hE3A00005);
        chk("word_latency", 32'(lat), 32'd3);

        // Byte and halfword writes, then reads
        txn(0, 1'b0, 2'b00, 8'h21, 32'h000000AB, 0, 1'b0, rv, lat);
        txn(0, 1'b0, 2'b01, 8'h22, 32'h00001234, 0, 1'b0, rv, lat);
        txn(0, 1'b1, 2'b10, 8'h20, 32'h0, 0, 1'b0, rv, lat);
        chk("mixed_word_read", rv, 32'h00AB1234);
        txn(0, 1'b1, 2'b01, 8'h23, 32'h0, 0, 1'b0, rv, lat);
        chk("half_align_read", rv, 32'h00001234);

        // Hold MemEn 4 cycles, release, immediate re-request
        txn(0, 1'b1, 2'b00, 8'h12, 32'h0, 4, 1'b0, rv, lat);
        chk("byte_read", rv, 32'h00000000);
        chk("moc_after_release", 32'(moc[0]), 32'd0);
        txn(0, 1'b1, 2'b00, 8'h10, 32'h0, 0, 1'b0, rv, lat);
        chk("rerequest_read", rv, 32'h000000E3);

        // Early release on a write: MOC is a single-cycle pulse
        txn(0, 1'b0, 2'b10, 8'h40, 32'hDEADBEEF, 0, 1'b1, rv, lat);
        chk("early_moc_pulse", 32'(moc[0]), 32'd0);
        txn(0, 1'b1, 2'b10, 8'h40, 32'h0, 0, 1'b0, rv, lat);
        chk("early_write_read", rv, 32'hDEADBEEF);

        // Reset during the wait states of a write
        rw = 1'b0; dt = 2'b10; addr = 8'h40; din = 32'h55555555; memen[0] = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("abort_moc", 32'(moc[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_data_out", dout[0], 32'h0);
        memen[0] = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        txn(0, 1'b1, 2'b10, 8'h40, 32'h0, 0, 1'b0, rv, lat);
        chk("abort_mem_kept", rv, 32'hDEADBEEF);
        txn(0, 1'b1, 2'b10, 8'h10, 32'h0, 0, 1'b0, rv, lat);
        chk("preload_kept", rv, 32'hE3A00005);

        // Zero wait states with a simultaneous load strobe
        load_byte(8'h80, 8'h11); load_byte(8'h81, 8'h22);
        load_byte(8'h82, 8'h33); load_byte(8'h83, 8'h44);
        ld_en = 1'b1; ld_addr = 8'h80; ld_data = 8'h77;
        txn(1, 1'b1, 2'b10, 8'h80, 32'h0, 0, 1'b0, rv, lat);
        chk("zw_latency", 32'(lat), 32'd1);
        chk("zw_read", rv, 32'h11223344);
        txn(1, 1'b1, 2'b00, 8'h80, 32'h0, 0, 1'b0, rv, lat);
        chk("conflict_load_dropped", rv, 32'h00000011);
        txn(0, 1'b1, 2'b00, 8'h80, 32'h0, 0, 1'b0, rv, lat);
        chk("idle_peer_loaded", rv, 32'h00000077);

        // Randomised traffic on both instances
        for (int k = 0; k < 400; k++) begin
            int d;
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0)
                load_byte(8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                ld_en = 1'b1; ld_addr = 8'($urandom); ld_data = 8'($urandom);
            end
            txn(d, 1'($urandom), 2'($urandom), 8'($urandom), $urandom,
                int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), rv, lat);
            chk($sformatf("latency%0d", d), 32'(lat), 32'(wait_of(d) + 1));
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
